// File: rtl/sram_dp_ctrl.sv
// sram_dp_ctrl: valid/ready front end for a 2048x16 dual-port SRAM macro with credit-based read response buffering
module sram_dp_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd_req_valid,
  output logic                               rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]              rd_req_addr,
  output logic                               rd_rsp_valid,
  input  logic                               rd_rsp_ready,
  output logic [DATA_WIDTH-1:0]              rd_rsp_data,
  output logic [$clog2(RSP_DEPTH+1)-1:0]     rd_outstanding,
  output logic                               sram_cen_a,
  output logic                               sram_rdwen_a,
  output logic [ADDR_WIDTH-1:0]              sram_a_a,
  output logic [DATA_WIDTH-1:0]              sram_d_a,
  output logic                               sram_cen_b,
  output logic                               sram_rdwen_b,
  output logic [ADDR_WIDTH-1:0]              sram_a_b,
  output logic [DATA_WIDTH-1:0]              sram_d_b,
  input  logic [DATA_WIDTH-1:0]              sram_q_b
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(RSP_DEPTH - 1);

  logic                  wr_hs, rd_hs, rsp_hs, push;
  logic                  cen_a_q, cen_a_d, cen_b_q, cen_b_d;
  logic [ADDR_WIDTH-1:0] a_a_q, a_a_d, a_b_q, a_b_d;
  logic [DATA_WIDTH-1:0] d_a_q, d_a_d;
  logic                  s1_q, s1_d, s2_q, s2_d;
  logic [CW-1:0]         cred_q, cred_d, fcnt_q, fcnt_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];

  assign wr_ready       = ~reset;
  assign rd_req_ready   = ~reset & (cred_q < DEPTH_C);
  assign rd_rsp_valid   = ~reset & (fcnt_q != '0);
  assign rd_rsp_data    = rd_rsp_valid ? fifo_q[rptr_q] : '0;
  assign rd_outstanding = reset ? '0 : cred_q;

  assign wr_hs  = wr_valid & wr_ready;
  assign rd_hs  = rd_req_valid & rd_req_ready;
  assign rsp_hs = rd_rsp_valid & rd_rsp_ready;
  assign push   = s2_q;

  // chip enables are forced off during reset so a write or read already on the pins is suppressed
  assign sram_cen_a   = cen_a_q | reset;
  assign sram_rdwen_a = 1'b0;
  assign sram_a_a     = a_a_q;
  assign sram_d_a     = d_a_q;
  assign sram_cen_b   = cen_b_q | reset;
  assign sram_rdwen_b = 1'b1;
  assign sram_a_b     = a_b_q;
  assign sram_d_b     = '0;

  // next state for pin registers, read pipeline, credit counter and response FIFO
  always_comb begin
    cen_a_d = ~wr_hs;
    a_a_d   = wr_hs ? wr_addr : a_a_q;
    d_a_d   = wr_hs ? wr_data : d_a_q;
    cen_b_d = ~rd_hs;
    a_b_d   = rd_hs ? rd_req_addr : a_b_q;
    s1_d    = rd_hs;
    s2_d    = s1_q;
    cred_d  = (rd_hs && !rsp_hs) ? cred_q + 1'b1 : (!rd_hs && rsp_hs) ? cred_q - 1'b1 : cred_q;
    fcnt_d  = (push && !rsp_hs) ? fcnt_q + 1'b1 : (!push && rsp_hs) ? fcnt_q - 1'b1 : fcnt_q;
    wptr_d  = push ? ((wptr_q == LAST_C) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d  = rsp_hs ? ((rptr_q == LAST_C) ? '0 : rptr_q + 1'b1) : rptr_q;
    fifo_d  = fifo_q;
    if (push) fifo_d[wptr_q] = sram_q_b;
  end

  // control and pin state with synchronous reset; reset discards in-flight reads and buffered data
  always_ff @(posedge clk) begin
    if (reset) begin
      cen_a_q <= 1'b1;
      a_a_q   <= '0;
      d_a_q   <= '0;
      cen_b_q <= 1'b1;
      a_b_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cred_q  <= '0;
      fcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      cen_a_q <= cen_a_d;
      a_a_q   <= a_a_d;
      d_a_q   <= d_a_d;
      cen_b_q <= cen_b_d;
      a_b_q   <= a_b_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cred_q  <= cred_d;
      fcnt_q  <= fcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // response storage needs no reset; validity comes from the FIFO count
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assert property (@(posedge clk) disable iff (reset)
    cred_q <= DEPTH_C && !(push && !rsp_hs && fcnt_q == DEPTH_C));
endmodule

// File: tb/tb_sram_dp_ctrl.sv
// tb_sram_dp_ctrl: randomized and directed checks of sram_dp_ctrl against a transaction-level memory model
module tb_sram_dp_ctrl;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr = '0;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready = 1'b0;
  logic [DW-1:0] rd_rsp_data;
  logic [2:0]    rd_outstanding;
  logic          sram_cen_a, sram_rdwen_a, sram_cen_b, sram_rdwen_b;
  logic [AW-1:0] sram_a_a, sram_a_b;
  logic [DW-1:0] sram_d_a, sram_d_b, sram_q_b;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            pre_cnt;
  logic          hs_req, hs_rsp, extra, obs_ready, obs_valid, exp_valid;
  logic [2:0]    obs_out;
  logic [DW-1:0] got, exp_d;
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  logic [DW-1:0] ref_mem [2**AW];
  rsp_t          exp_q [$];

  always #5 clk = ~clk;

  sram_dp_ctrl dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .rd_outstanding(rd_outstanding),
    .sram_cen_a(sram_cen_a), .sram_rdwen_a(sram_rdwen_a), .sram_a_a(sram_a_a), .sram_d_a(sram_d_a),
    .sram_cen_b(sram_cen_b), .sram_rdwen_b(sram_rdwen_b), .sram_a_b(sram_a_b), .sram_d_b(sram_d_b),
    .sram_q_b(sram_q_b)
  );

  function automatic logic [DW-1:0] init_val(int i);
    return DW'(i * 40503) ^ DW'(i >> 5) ^ 16'hC5A1;
  endfunction

  // macro model: registered read port, Q_B valid one cycle, junk otherwise; read-before-write on the same edge
  initial begin
    logic [DW-1:0] macro_mem [2**AW];
    for (int i = 0; i < 2**AW; i++) macro_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      sram_q_b <= (!sram_cen_b && sram_rdwen_b) ? macro_mem[sram_a_b] : DW'($urandom);
      if (!sram_cen_a && !sram_rdwen_a) macro_mem[sram_a_a] <= sram_d_a;
    end
  end

  // one clock cycle: sample at negedge, advance the transaction model, return just after the next posedge
  task automatic tick();
    rsp_t r;
    @(negedge clk);
    obs_ready = rd_req_ready;
    obs_out   = rd_outstanding;
    obs_valid = rd_rsp_valid;
    got       = rd_rsp_data;
    pre_cnt   = exp_q.size();
    exp_valid = !reset && exp_q.size() > 0 && cyc >= exp_q[0].due;
    hs_req    = rd_req_valid && rd_req_ready;
    hs_rsp    = rd_rsp_valid && rd_rsp_ready;
    extra     = 1'b0;
    exp_d     = '0;
    if (pend_v && !reset) ref_mem[pend_a] = pend_d;
    pend_v = 1'b0;
    if (reset) exp_q.delete();
    else begin
      if (hs_rsp) begin
        if (exp_q.size() == 0) extra = 1'b1;
        else begin
          r = exp_q.pop_front();
          exp_d = r.data;
        end
      end
      if (hs_req) begin
        r.data = ref_mem[rd_req_addr];
        r.due  = cyc + 3;
        exp_q.push_back(r);
      end
      if (wr_valid && wr_ready) begin
        pend_v = 1'b1;
        pend_a = wr_addr;
        pend_d = wr_data;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; wr_valid = 1; rd_req_valid = 1; rd_rsp_ready = 1;
    wr_addr = 11'h123; wr_data = 16'h4567; rd_req_addr = 11'h055;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total += 6;
      if (sram_cen_a !== 1'b1) begin bad++; $display("FAIL rst_cen_a cyc%0d got=%b want=1", i, sram_cen_a); end
      if (sram_cen_b !== 1'b1) begin bad++; $display("FAIL rst_cen_b cyc%0d got=%b want=1", i, sram_cen_b); end
      if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready cyc%0d got=%b want=0", i, wr_ready); end
      if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL rst_rd_req_ready cyc%0d got=%b want=0", i, rd_req_ready); end
      if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid cyc%0d got=%b want=0", i, rd_rsp_valid); end
      if (rd_outstanding !== 3'd0) begin bad++; $display("FAIL rst_outstanding cyc%0d got=%0d want=0", i, rd_outstanding); end
    end
    total += 7;
    if (sram_a_a !== '0) begin bad++; $display("FAIL rst_a_a got=%h want=0", sram_a_a); end
    if (sram_d_a !== '0) begin bad++; $display("FAIL rst_d_a got=%h want=0", sram_d_a); end
    if (sram_a_b !== '0) begin bad++; $display("FAIL rst_a_b got=%h want=0", sram_a_b); end
    if (rd_rsp_data !== '0) begin bad++; $display("FAIL rst_rsp_data got=%h want=0", rd_rsp_data); end
    if (sram_rdwen_a !== 1'b0) begin bad++; $display("FAIL rdwen_a got=%b want=0", sram_rdwen_a); end
    if (sram_rdwen_b !== 1'b1) begin bad++; $display("FAIL rdwen_b got=%b want=1", sram_rdwen_b); end
    if (sram_d_b !== '0) begin bad++; $display("FAIL d_b got=%h want=0", sram_d_b); end
    @(posedge clk);
    #1;
    reset = 0; wr_valid = 0; rd_req_valid = 0;
    tick();
    total += 4;
    if (obs_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", obs_ready); end
    if (obs_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", obs_valid); end
    if (obs_out !== 3'd0) begin bad++; $display("FAIL post_rst_out got=%0d want=0", obs_out); end
    if (sram_cen_a !== 1'b1) begin bad++; $display("FAIL post_rst_cen_a got=%b want=1", sram_cen_a); end
  endtask

  task automatic test_write_read();
    rd_rsp_ready = 1; wr_valid = 1; wr_addr = 11'h7FF; wr_data = 16'hBEEF; rd_req_valid = 0;
    tick();
    total += 3;
    if (sram_cen_a !== 1'b0) begin bad++; $display("FAIL wr_cen_a got=%b want=0", sram_cen_a); end
    if (sram_a_a !== 11'h7FF) begin bad++; $display("FAIL wr_a_a got=%h want=7ff", sram_a_a); end
    if (sram_d_a !== 16'hBEEF) begin bad++; $display("FAIL wr_d_a got=%h want=beef", sram_d_a); end
    wr_valid = 0; rd_req_valid = 1; rd_req_addr = 11'h7FF;
    tick();
    total += 4;
    if (hs_req !== 1'b1) begin bad++; $display("FAIL wr_rd_accept got=%b want=1", hs_req); end
    if (sram_cen_b !== 1'b0) begin bad++; $display("FAIL rd_cen_b got=%b want=0", sram_cen_b); end
    if (sram_a_b !== 11'h7FF) begin bad++; $display("FAIL rd_a_b got=%h want=7ff", sram_a_b); end
    if (sram_cen_a !== 1'b1) begin bad++; $display("FAIL idle_cen_a got=%b want=1", sram_cen_a); end
    rd_req_valid = 0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      total++;
      if (obs_valid !== (i == 4)) begin bad++; $display("FAIL wr_rd_latency cyc%0d got=%b want=%b", i, obs_valid, i == 4); end
      if (i == 4) begin
        total += 2;
        if (got !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_data got=%h want=beef", got); end
        if (extra || got !== exp_d) begin bad++; $display("FAIL wr_rd_model got=%h want=%h", got, exp_d); end
      end
    end
  endtask

  task automatic test_hazard();
    logic [DW-1:0] seen [2];
    int n = 0;
    rd_rsp_ready = 1; wr_valid = 1; wr_addr = 11'h010; wr_data = 16'h1111; rd_req_valid = 0;
    tick();
    wr_data = 16'h2222; rd_req_valid = 1; rd_req_addr = 11'h010;
    tick();
    wr_valid = 0;
    tick();
    rd_req_valid = 0;
    for (int i = 0; i < 12 && n < 2; i++) begin
      tick();
      if (hs_rsp) begin
        seen[n] = got;
        n++;
      end
    end
    total += 3;
    if (n != 2) begin bad++; $display("FAIL hazard_count got=%0d want=2", n); end
    if (n > 0 && seen[0] !== 16'h1111) begin bad++; $display("FAIL hazard_old got=%h want=1111", seen[0]); end
    if (n > 1 && seen[1] !== 16'h2222) begin bad++; $display("FAIL hazard_new got=%h want=2222", seen[1]); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_rsp = 0;
    int first = -1;
    rd_rsp_ready = 0; rd_req_valid = 0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_addr = 11'(i); wr_data = 16'(16'hA0 + i);
      tick();
    end
    wr_valid = 0;
    for (int k = 0; k < 6; k++) begin
      rd_req_valid = 1; rd_req_addr = 11'(n_acc);
      tick();
      if (hs_req) n_acc++;
    end
    total++;
    if (n_acc != DEPTH) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", n_acc, DEPTH); end
    for (int k = 0; k < 3; k++) begin
      rd_req_valid = 1; rd_req_addr = 11'(n_acc);
      tick();
      if (hs_req) n_acc++;
      total += 4;
      if (obs_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", obs_ready); end
      if (obs_out !== 3'd4) begin bad++; $display("FAIL bp_outstanding got=%0d want=4", obs_out); end
      if (obs_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", obs_valid); end
      if (got !== 16'h00A0) begin bad++; $display("FAIL bp_stable got=%h want=00a0", got); end
    end
    rd_rsp_ready = 1;
    for (int k = 0; k < 30 && n_rsp < 6; k++) begin
      rd_req_valid = (n_acc < 6); rd_req_addr = 11'(n_acc);
      tick();
      if (hs_req) n_acc++;
      if (k == first + 1 && first >= 0) begin
        total++;
        if (obs_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got=%b want=1", obs_ready); end
      end
      if (hs_rsp) begin
        if (first < 0) begin
          first = k;
          total++;
          if (obs_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_at_pop got=%b want=0", obs_ready); end
        end
        total += 2;
        if (got !== 16'(16'hA0 + n_rsp)) begin bad++; $display("FAIL bp_order idx%0d got=%h want=%h", n_rsp, got, 16'(16'hA0 + n_rsp)); end
        if (extra || got !== exp_d) begin bad++; $display("FAIL bp_model idx%0d got=%h want=%h", n_rsp, got, exp_d); end
        n_rsp++;
      end
    end
    rd_req_valid = 0;
    total++;
    if (n_rsp != 6) begin bad++; $display("FAIL bp_drain got=%0d want=6", n_rsp); end
  endtask

  task automatic test_stream();
    int n_rsp = 0;
    rd_rsp_ready = 1; wr_valid = 0;
    for (int k = 0; k < 2048 + 6; k++) begin
      rd_req_valid = (k < 2048); rd_req_addr = 11'(k);
      tick();
      total += 3;
      if (hs_req !== (k < 2048)) begin bad++; $display("FAIL stream_accept k%0d got=%b want=%b", k, hs_req, k < 2048); end
      if (obs_valid !== (k >= 3 && k < 2051)) begin bad++; $display("FAIL stream_valid k%0d got=%b want=%b", k, obs_valid, k >= 3 && k < 2051); end
      if (obs_valid !== exp_valid) begin bad++; $display("FAIL stream_timing k%0d got=%b want=%b", k, obs_valid, exp_valid); end
      if (hs_rsp) begin
        n_rsp++;
        total++;
        if (extra || got !== exp_d) begin bad++; $display("FAIL stream_data k%0d got=%h want=%h", k, got, exp_d); end
      end
    end
    rd_req_valid = 0;
    total++;
    if (n_rsp != 2048) begin bad++; $display("FAIL stream_count got=%0d want=2048", n_rsp); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rd_rsp_ready = 1; wr_valid = 1; wr_addr = 11'h020; wr_data = 16'h0F0F; rd_req_valid = 0;
    tick();
    rd_rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rd_req_valid = 1; rd_req_addr = 11'(11'h030 + i);
      wr_valid = (i == 2); wr_data = 16'h5A5A;
      tick();
      total++;
      if (hs_req !== 1'b1) begin bad++; $display("FAIL mid_accept i%0d got=%b want=1", i, hs_req); end
    end
    rd_req_valid = 0; wr_valid = 0; reset = 1;
    tick();
    total += 2;
    if (obs_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", obs_valid); end
    if (sram_cen_a !== 1'b1) begin bad++; $display("FAIL mid_rst_cen_a got=%b want=1", sram_cen_a); end
    reset = 0; rd_rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total += 2;
      if (obs_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_valid i%0d got=%b want=0", i, obs_valid); end
      if (obs_out !== 3'd0) begin bad++; $display("FAIL mid_outstanding i%0d got=%0d want=0", i, obs_out); end
    end
    rd_req_valid = 1; rd_req_addr = 11'h020;
    tick();
    rd_req_valid = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      tick();
      if (hs_rsp) begin
        n++;
        total++;
        if (got !== 16'h0F0F) begin bad++; $display("FAIL mid_dropped_write got=%h want=0f0f", got); end
      end
    end
    total++;
    if (n != 1) begin bad++; $display("FAIL mid_new_read got=%0d want=1", n); end
  endtask

  task automatic test_random();
    logic want_ready;
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      wr_valid     = 1'($urandom_range(0, 1));
      wr_addr      = 11'($urandom_range(0, 15));
      wr_data      = 16'($urandom);
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_req_addr  = 11'($urandom_range(0, 15));
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      want_ready = !reset && pre_cnt < DEPTH;
      total += 3;
      if (obs_ready !== want_ready) begin bad++; $display("FAIL rnd_ready i%0d got=%b want=%b", i, obs_ready, want_ready); end
      if (obs_out !== 3'(reset ? 0 : pre_cnt)) begin bad++; $display("FAIL rnd_outstanding i%0d got=%0d want=%0d", i, obs_out, reset ? 0 : pre_cnt); end
      if (obs_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid i%0d got=%b want=%b", i, obs_valid, exp_valid); end
      if (hs_rsp) begin
        total++;
        if (extra || got !== exp_d) begin bad++; $display("FAIL rnd_data i%0d got=%h want=%h", i, got, exp_d); end
      end
    end
    reset = 0; wr_valid = 0; rd_req_valid = 0; rd_rsp_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hs_rsp) begin
        total++;
        if (extra || got !== exp_d) begin bad++; $display("FAIL rnd_drain_data got=%h want=%h", got, exp_d); end
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_write_read();
    test_hazard();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
